ifft_bf_sequencer: RTL and testbench



---
 rtl/ifft_pkg.sv | 23 ++
 rtl/ifft_bf_addr_calc.sv | 26 ++
 rtl/ifft_bf_sequencer.sv | 147 ++++++++++++++
 tb/tb_ifft_bf_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
// Shared constants, FSM encoding and helpers for the 16-point IFFT/FFT butterfly sequencers.
package ifft_pkg;

  localparam int unsigned IFFT_N      = 16;
  localparam int unsigned IFFT_STAGES = 4;
  localparam int unsigned IFFT_AW     = 4;

  // First twiddle ROM word of each stage: WN16^0..7, WN8^0..3, WN4^0..1, WN2^0.
  localparam logic [3:0][3:0] TW_BASE = {4'd14, 4'd12, 4'd8, 4'd0};

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    UNLOAD,
    DONE
  } state_e;

  function automatic logic [3:0] bitrev(input logic [3:0] i_k);
    return {i_k[0], i_k[1], i_k[2], i_k[3]};
  endfunction

endpackage

// File: rtl/ifft_bf_addr_calc.sv
// Radix-2 DIF operand-pair and twiddle address generation for one butterfly (combinational).
module ifft_bf_addr_calc
  import ifft_pkg::*;
(
  input  logic [1:0]         i_stage,
  input  logic [2:0]         i_cnt,
  output logic [IFFT_AW-1:0] o_addr_a,
  output logic [IFFT_AW-1:0] o_addr_b,
  output logic [IFFT_AW-1:0] o_tw_rd_add
);

  logic [3:0] w_span;
  logic [3:0] w_j;
  logic [3:0] w_g;

  always_comb begin
    w_span      = 4'd8 >> i_stage;
    w_j         = {1'b0, i_cnt} & (w_span - 4'd1);
    // Group index selects which 2*span block the butterfly sits in.
    w_g         = {1'b0, i_cnt} >> (2'd3 - i_stage);
    o_addr_a    = (w_g << (3'd4 - {1'b0, i_stage})) | w_j;
    o_addr_b    = o_addr_a + w_span;
    o_tw_rd_add = TW_BASE[i_stage] + w_j;
  end

endmodule

// File: rtl/ifft_bf_sequencer.sv
// Stage/butterfly sequencer for the 16-point IFFT: issues operand and twiddle addresses per stage,
// waits out the datapath latency between stages, then unloads results in bit-reversed order.
module ifft_bf_sequencer
  import ifft_pkg::*;
#(
  parameter int unsigned BF_LAT = 3,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              bf_ready,
  input  logic              out_ready,
  output logic              busy,
  output logic              bf_valid,
  output logic [ADDR_W-1:0] bf_addr_a,
  output logic [ADDR_W-1:0] bf_addr_b,
  output logic [ADDR_W-1:0] tw_rd_add,
  output logic [1:0]        stage,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_rd_add,
  output logic              done
);

  localparam int unsigned LatW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
  localparam logic [LatW-1:0] LatLast = LatW'(BF_LAT - 1);
  localparam logic [2:0] CntLast = 3'(IFFT_N / 2 - 1);

  state_e            r_state, w_state_d;
  logic [1:0]        r_stage, w_stage_d;
  logic [2:0]        r_cnt, w_cnt_d;
  logic [LatW-1:0]   r_lat, w_lat_d;
  logic [3:0]        r_k, w_k_d;

  logic              r_busy, r_bf_valid, r_out_valid, r_done;
  logic [ADDR_W-1:0] r_addr_a, r_addr_b, r_tw, r_out_add;
  logic [ADDR_W-1:0] w_addr_a, w_addr_b, w_tw;
  logic              w_issue_d, w_unload_d;

  // Addresses are computed from next-state counters so the registered outputs line up with state.
  ifft_bf_addr_calc u_addr_calc (
    .i_stage     (w_stage_d),
    .i_cnt       (w_cnt_d),
    .o_addr_a    (w_addr_a),
    .o_addr_b    (w_addr_b),
    .o_tw_rd_add (w_tw)
  );

  always_comb begin
    w_state_d = r_state;
    w_stage_d = r_stage;
    w_cnt_d   = r_cnt;
    w_lat_d   = r_lat;
    w_k_d     = r_k;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_d = ISSUE;
          w_stage_d = 2'd0;
          w_cnt_d   = 3'd0;
        end
      end
      ISSUE: begin
        if (bf_ready) begin
          if (r_cnt == CntLast) begin
            w_state_d = DRAIN;
            w_lat_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 3'd1;
          end
        end
      end
      DRAIN: begin
        if (r_lat == LatLast) begin
          w_lat_d = '0;
          if (r_stage == 2'(IFFT_STAGES - 1)) begin
            w_state_d = UNLOAD;
            w_k_d     = 4'd0;
          end else begin
            w_state_d = ISSUE;
            w_stage_d = r_stage + 2'd1;
            w_cnt_d   = 3'd0;
          end
        end else begin
          w_lat_d = r_lat + 1'b1;
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          if (r_k == 4'(IFFT_N - 1)) begin
            w_state_d = DONE;
            w_k_d     = 4'd0;
          end else begin
            w_k_d = r_k + 4'd1;
          end
        end
      end
      DONE: w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
    w_issue_d  = (w_state_d == ISSUE);
    w_unload_d = (w_state_d == UNLOAD);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_stage     <= '0;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_k         <= '0;
      r_busy      <= 1'b0;
      r_bf_valid  <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_tw        <= '0;
      r_out_valid <= 1'b0;
      r_out_add   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_stage     <= w_stage_d;
      r_cnt       <= w_cnt_d;
      r_lat       <= w_lat_d;
      r_k         <= w_k_d;
      r_busy      <= (w_state_d != IDLE);
      r_bf_valid  <= w_issue_d;
      r_addr_a    <= w_issue_d ? w_addr_a : '0;
      r_addr_b    <= w_issue_d ? w_addr_b : '0;
      r_tw        <= w_issue_d ? w_tw : '0;
      r_out_valid <= w_unload_d;
      r_out_add   <= w_unload_d ? bitrev(w_k_d) : '0;
      r_done      <= (w_state_d == DONE);
    end
  end

  assign busy       = r_busy;
  assign bf_valid   = r_bf_valid;
  assign bf_addr_a  = r_addr_a;
  assign bf_addr_b  = r_addr_b;
  assign tw_rd_add  = r_tw;
  assign stage      = r_stage;
  assign out_valid  = r_out_valid;
  assign out_rd_add = r_out_add;
  assign done       = r_done;

endmodule

// File: tb/tb_ifft_bf_sequencer.sv
// Self-checking bench for ifft_bf_sequencer: scoreboard of issues/unloads/done cycles plus spot table.
module tb_ifft_bf_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  logic       bf_ready = 1'b1;
  logic       out_ready = 1'b1;
  logic       start_aux = 1'b0;

  logic       busy, bf_valid, out_valid, done;
  logic [3:0] bf_addr_a, bf_addr_b, tw_rd_add, out_rd_add;
  logic [1:0] stage;

  logic       x1_busy, x1_bf_valid, x1_out_valid, x1_done;
  logic [3:0] x1_a, x1_b, x1_tw, x1_out;
  logic [1:0] x1_stage;
  logic       x5_busy, x5_bf_valid, x5_out_valid, x5_done;
  logic [3:0] x5_a, x5_b, x5_tw, x5_out;
  logic [1:0] x5_stage;

  always #5 CLK = ~CLK;

  ifft_bf_sequencer #(.BF_LAT(3), .ADDR_W(4)) dut (
    .CLK(CLK), .RST(RST), .start(start), .bf_ready(bf_ready), .out_ready(out_ready),
    .busy(busy), .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .tw_rd_add(tw_rd_add), .stage(stage), .out_valid(out_valid), .out_rd_add(out_rd_add),
    .done(done)
  );

  ifft_bf_sequencer #(.BF_LAT(1), .ADDR_W(4)) dut_lat1 (
    .CLK(CLK), .RST(RST), .start(start_aux), .bf_ready(1'b1), .out_ready(1'b1),
    .busy(x1_busy), .bf_valid(x1_bf_valid), .bf_addr_a(x1_a), .bf_addr_b(x1_b),
    .tw_rd_add(x1_tw), .stage(x1_stage), .out_valid(x1_out_valid), .out_rd_add(x1_out),
    .done(x1_done)
  );

  ifft_bf_sequencer #(.BF_LAT(5), .ADDR_W(4)) dut_lat5 (
    .CLK(CLK), .RST(RST), .start(start_aux), .bf_ready(1'b1), .out_ready(1'b1),
    .busy(x5_busy), .bf_valid(x5_bf_valid), .bf_addr_a(x5_a), .bf_addr_b(x5_b),
    .tw_rd_add(x5_tw), .stage(x5_stage), .out_valid(x5_out_valid), .out_rd_add(x5_out),
    .done(x5_done)
  );

  typedef struct {
    bit is_out;
    int idx;
    int st;
    int a;
    int b;
    int tw;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [13:0] exp_iss[$];
  logic [13:0] obs_iss[$];
  logic [3:0]  exp_out[$];
  logic [3:0]  obs_out[$];
  int          exp_done[$];
  bit          stall_prev = 1'b0;
  logic [13:0] stall_snap = '0;
  int          last0_1 = -1, first1_1 = -1, last0_5 = -1, first1_5 = -1;
  vec_t        tbl[22];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [13:0] pk(input int s, input int a, input int b, input int tw);
    return {s[1:0], a[3:0], b[3:0], tw[3:0]};
  endfunction

  // Expected 32 issues, 16 unload addresses and the done cycle for a run started this cycle.
  task automatic push_run(input int lat);
    logic [3:0] kk, rv;
    for (int s = 0; s < 4; s++) begin
      int span = 8 >> s;
      for (int g = 0; g < (1 << s); g++)
        for (int j = 0; j < span; j++)
          exp_iss.push_back(pk(s, g * 2 * span + j, g * 2 * span + j + span,
                               16 - (16 >> s) + j));
    end
    for (int k = 0; k < 16; k++) begin
      kk = k[3:0];
      for (int i = 0; i < 4; i++) rv[i] = kk[3-i];
      exp_out.push_back(rv);
    end
    exp_done.push_back(cyc + lat);
  endtask

  task automatic monitor();
    logic [13:0] cur;
    cur = pk(int'(stage), int'(bf_addr_a), int'(bf_addr_b), int'(tw_rd_add));
    if (bf_valid) check("tw_not_15", int'(tw_rd_add == 4'd15), 0);
    if (stall_prev) check("stall_hold", int'({bf_valid, cur}), int'({1'b1, stall_snap}));
    stall_prev = bf_valid && !bf_ready;
    stall_snap = cur;
    if (bf_valid && bf_ready) begin
      obs_iss.push_back(cur);
      if (exp_iss.size() == 0) check("issue_unexpected", int'(cur), -1);
      else check("issue", int'(cur), int'(exp_iss.pop_front()));
    end
    if (out_valid && out_ready) begin
      obs_out.push_back(out_rd_add);
      if (exp_out.size() == 0) check("unload_unexpected", int'(out_rd_add), -1);
      else check("unload", int'(out_rd_add), int'(exp_out.pop_front()));
    end
    if (done) begin
      check("busy_with_done", int'(busy), 1);
      if (exp_done.size() == 0) check("done_unexpected", cyc, -1);
      else check("done_cycle", cyc, exp_done.pop_front());
    end
    if (x1_bf_valid && x1_stage == 2'd0 && x1_a == 4'd7) last0_1 = cyc;
    if (x1_bf_valid && x1_stage == 2'd1 && first1_1 < 0) first1_1 = cyc;
    if (x5_bf_valid && x5_stage == 2'd0 && x5_a == 4'd7) last0_5 = cyc;
    if (x5_bf_valid && x5_stage == 2'd1 && first1_5 < 0) first1_5 = cyc;
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && exp_done.size() != 0; i++) tick();
    check("run_complete", exp_done.size(), 0);
  endtask

  function automatic int all_outs();
    return int'({busy, bf_valid, bf_addr_a, bf_addr_b, tw_rd_add, stage, out_valid,
                 out_rd_add, done});
  endfunction

  initial begin
    tbl = '{
      '{0, 0, 0, 0, 8, 0},   '{0, 1, 0, 1, 9, 1},    '{0, 3, 0, 3, 11, 3},
      '{0, 7, 0, 7, 15, 7},  '{0, 8, 1, 0, 4, 8},    '{0, 9, 1, 1, 5, 9},
      '{0, 11, 1, 3, 7, 11}, '{0, 12, 1, 8, 12, 8},  '{0, 15, 1, 11, 15, 11},
      '{0, 16, 2, 0, 2, 12}, '{0, 17, 2, 1, 3, 13},  '{0, 18, 2, 4, 6, 12},
      '{0, 24, 3, 0, 1, 14}, '{0, 25, 3, 2, 3, 14},  '{0, 31, 3, 14, 15, 14},
      '{1, 0, 0, 0, 0, 0},   '{1, 1, 0, 8, 0, 0},    '{1, 2, 0, 4, 0, 0},
      '{1, 3, 0, 12, 0, 0},  '{1, 4, 0, 2, 0, 0},    '{1, 5, 0, 10, 0, 0},
      '{1, 15, 0, 15, 0, 0}
    };

    // Reset state
    tick();
    tick();
    check("reset_outs", all_outs(), 0);
    RST = 1'b0;
    tick();

    // 1: uninterrupted run, plus the BF_LAT=1/5 instances in parallel
    obs_iss.delete();
    obs_out.delete();
    start = 1'b1;
    start_aux = 1'b1;
    push_run(61);
    tick();
    start = 1'b0;
    start_aux = 1'b0;
    check("busy_rise", int'(busy), 1);
    wait_idle(100);
    check("busy_fall", int'(busy), 0);
    check("issue_count", obs_iss.size(), 32);
    check("unload_count", obs_out.size(), 16);
    for (int i = 0; i < 22; i++) begin
      if (tbl[i].is_out) begin
        check($sformatf("tbl_out[%0d]", tbl[i].idx),
              (tbl[i].idx < obs_out.size()) ? int'(obs_out[tbl[i].idx]) : -1, tbl[i].a);
      end else begin
        check($sformatf("tbl_iss[%0d]", tbl[i].idx),
              (tbl[i].idx < obs_iss.size()) ? int'(obs_iss[tbl[i].idx]) : -1,
              int'(pk(tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].tw)));
      end
    end

    // 3: five-cycle bf_ready stall while stage 0 cnt 3 is presented
    start = 1'b1;
    push_run(66);
    tick();
    start = 1'b0;
    repeat (3) tick();
    bf_ready = 1'b0;
    repeat (5) tick();
    bf_ready = 1'b1;
    wait_idle(100);

    // 4: starts during ISSUE/DRAIN/UNLOAD/DONE ignored; start right after done accepted
    start = 1'b1;
    push_run(61);
    tick();
    for (int i = 1; i <= 62; i++) begin
      start = (i == 3 || i == 10 || i == 50 || i == 61 || i == 62);
      if (i == 62) begin
        check("busy_idle_gap", int'(busy), 0);
        push_run(61);
      end
      tick();
    end
    start = 1'b0;
    wait_idle(100);

    // 5: reset at stage 2 cnt 1 aborts with no done, then a clean rerun
    start = 1'b1;
    push_run(61);
    tick();
    start = 1'b0;
    repeat (23) tick();
    check("rst_point", int'({stage, bf_addr_a}), int'({2'd2, 4'd1}));
    RST = 1'b1;
    tick();
    check("abort_outs", all_outs(), 0);
    RST = 1'b0;
    exp_iss.delete();
    exp_out.delete();
    exp_done.delete();
    repeat (5) tick();
    start = 1'b1;
    push_run(61);
    tick();
    start = 1'b0;
    wait_idle(100);

    // 6: stage barrier length for BF_LAT=1 and BF_LAT=5
    check("drain_gap_lat1", first1_1 - last0_1, 2);
    check("drain_gap_lat5", first1_5 - last0_5, 6);
    check("leftover", exp_iss.size() + exp_out.size() + exp_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
